// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states and reset PC.
// Latency: none (types and constants only).
// Backpressure: none.
package fetch_pkg;

    // PC the fetch stage starts from after reset.
    localparam logic [31:0] FETCH_BASEADDR = 32'h0100_0000;

    // Fixed instruction size; sequential fetch advances by this many bytes.
    localparam int unsigned FETCH_PC_STEP = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,  // post-reset settle, or halted after a misaligned redirect
        ST_REQ  = 3'd1,  // request presented, waiting for the memory to accept it
        ST_WAIT = 3'd2,  // one request outstanding, waiting for its response
        ST_HOLD = 3'd3,  // instruction presented to decode, waiting for consume
        ST_DROP = 3'd4   // redirected while outstanding; next response is stale
    } fetch_state_e;

endpackage

// File: rtl/fetch_obuf.sv
// Output register for the fetch stage: holds insn/pc/valid presented to decode.
// Latency: 1 cycle from load_i to valid_o; clear_i drops valid_o the next cycle.
// Backpressure: none internally; contents stay put until the parent loads or clears.
//
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   load_i          capture insn_i/pc_i and set valid
//   clear_i         drop valid (data left as is)
//   insn_i, pc_i    instruction word and its PC to capture
//   valid_o, insn_o, pc_o  registered view for decode
module fetch_obuf
    import fetch_pkg::*;
#(
    parameter int                DWIDTH = 32,
    parameter int                AWIDTH = 32,
    parameter logic [AWIDTH-1:0] RST_PC = AWIDTH'(FETCH_BASEADDR)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [DWIDTH-1:0] insn_i,
    input  logic [AWIDTH-1:0] pc_i,
    output logic              valid_o,
    output logic [DWIDTH-1:0] insn_o,
    output logic [AWIDTH-1:0] pc_o
);

    logic              valid_q;
    logic [DWIDTH-1:0] insn_q;
    logic [AWIDTH-1:0] pc_q;

    // Load wins over clear; the parent never asserts both in one cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            insn_q  <= '0;
            pc_q    <= RST_PC;
        end else if (load_i) begin
            valid_q <= 1'b1;
            insn_q  <= insn_i;
            pc_q    <= pc_i;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign insn_o  = insn_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one-outstanding-request fetch FSM feeding decode.
// Latency: request 1 cycle after REQ entry, insn_valid_o 1 cycle after response (3 cycles/insn at zero mem latency).
// Backpressure: holds insn_o/pc_o while insn_ready_i=0 and issues no new request; request held until accepted.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   imem_req_*               request channel to instruction memory (valid/ready, address)
//   imem_rsp_*               response from instruction memory (valid, data)
//   redirect_i/_pc_i         taken branch/jump and its target
//   insn_valid_o/_ready_i    handshake to decode; insn_o/pc_o carry the instruction
//   misalign_o               sticky flag for a misaligned redirect target
//
// Build option FETCH_MISALIGN_TRAP_EN: when defined, a redirect target with
// nonzero low two bits sets misalign_o and parks the stage in IDLE until reset.
// When undefined, the low two bits of the target are forced to zero.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int                DWIDTH   = 32,
    parameter int                AWIDTH   = 32,
    parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(FETCH_BASEADDR)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid_o,
    input  logic              imem_req_ready_i,
    output logic [AWIDTH-1:0] imem_addr_o,
    input  logic              imem_rsp_valid_i,
    input  logic [DWIDTH-1:0] imem_rsp_data_i,
    input  logic              redirect_i,
    input  logic [AWIDTH-1:0] redirect_pc_i,
    output logic              insn_valid_o,
    input  logic              insn_ready_i,
    output logic [DWIDTH-1:0] insn_o,
    output logic [AWIDTH-1:0] pc_o,
    output logic              misalign_o
);

    fetch_state_e      state_q, state_d;
    logic [AWIDTH-1:0] pc_q, pc_d;
    logic              obuf_load;
    logic              obuf_clear;
    logic [AWIDTH-1:0] redir_pc;   // target as it will be loaded into pc
    logic              redir_bad;  // this redirect trips the misalign trap
    logic              halted;     // trap has fired; stage is parked

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;

    assign redir_pc   = redirect_pc_i;
    assign redir_bad  = redirect_i && (redirect_pc_i[1:0] != 2'b00);
    assign misalign_d = misalign_q | redir_bad;
    assign halted     = misalign_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign_o = misalign_q;
`else
    assign redir_pc   = redirect_pc_i & ~(AWIDTH'(3));
    assign redir_bad  = 1'b0;
    assign halted     = 1'b0;
    assign misalign_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pc_q    <= BASEADDR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // A redirect in REQ withdraws the request in the same cycle so memory can
    // never accept the stale address.
    assign imem_req_valid_o = (state_q == ST_REQ) && !redirect_i;
    assign imem_addr_o      = pc_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        obuf_load  = 1'b0;
        obuf_clear = 1'b0;

        if (redirect_i && !halted) begin
            // Redirect outranks every other event, including a decode consume.
            pc_d       = redir_pc;
            obuf_clear = 1'b1;
            if (redir_bad) begin
                state_d = ST_IDLE;
            end else if ((state_q == ST_WAIT) || (state_q == ST_DROP)) begin
                // A response in this same cycle is the stale one: drop it and
                // refetch directly; otherwise wait for it in DROP.
                state_d = imem_rsp_valid_i ? ST_REQ : ST_DROP;
            end else begin
                state_d = ST_REQ;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!halted) begin
                        state_d = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (imem_req_ready_i) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rsp_valid_i) begin
                        obuf_load = 1'b1;
                        state_d   = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (insn_ready_i) begin
                        pc_d       = pc_q + AWIDTH'(FETCH_PC_STEP);
                        obuf_clear = 1'b1;
                        state_d    = ST_REQ;
                    end
                end
                ST_DROP: begin
                    if (imem_rsp_valid_i) begin
                        state_d = ST_REQ;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    fetch_obuf #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH),
        .RST_PC (BASEADDR)
    ) u_obuf (
        .clk     (clk),
        .rst     (rst),
        .load_i  (obuf_load),
        .clear_i (obuf_clear),
        .insn_i  (imem_rsp_data_i),
        .pc_i    (pc_q),
        .valid_o (insn_valid_o),
        .insn_o  (insn_o),
        .pc_o    (pc_o)
    );

endmodule
